// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake and integer baud divider.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after data bit 7.
module uart_tx #(
    parameter int unsigned CLK_FRE    = 100,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_busy,
    output logic       tx_pin
);

    localparam int unsigned CYCLE      = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_SEND_BYTE = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_cycle_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_tx_pin;
    logic        r_ready;
    logic        r_busy;

    state_t      w_state_d;
    logic [15:0] w_cycle_d;
    logic [2:0]  w_bit_d;
    logic [7:0]  w_shift_d;
    logic        w_pin_d;
    logic        w_bit_end;

`ifdef UART_TX_PARITY_EN
    logic w_parity;
    assign w_parity = (^r_shift) ^ PARITY_ODD;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
`endif

    assign w_bit_end = (r_cycle_cnt == CYCLE_LAST);

    always_comb begin
        w_state_d = r_state;
        w_cycle_d = r_cycle_cnt + 16'd1;
        w_bit_d   = 3'd0;
        w_shift_d = r_shift;

        unique case (r_state)
            S_IDLE: begin
                w_cycle_d = 16'd0;
                if (tx_data_valid && r_ready) begin
                    w_state_d = S_START;
                    w_shift_d = tx_data;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_d = S_SEND_BYTE;
                    w_cycle_d = 16'd0;
                end
            end
            S_SEND_BYTE: begin
                w_bit_d = r_bit_cnt;
                if (w_bit_end) begin
                    w_cycle_d = 16'd0;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_d = S_PARITY;
`else
                        w_state_d = S_STOP;
`endif
                    end else begin
                        w_bit_d = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_d = S_STOP;
                    w_cycle_d = 16'd0;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_d = S_IDLE;
                    w_cycle_d = 16'd0;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_cycle_d = 16'd0;
            end
        endcase
    end

    // Line level is registered from the next state so it changes on the same edge as the state.
    always_comb begin
        w_pin_d = 1'b1;
        unique case (w_state_d)
            S_START:     w_pin_d = 1'b0;
            S_SEND_BYTE: w_pin_d = w_shift_d[w_bit_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY:    w_pin_d = w_parity;
`endif
            default:     w_pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cycle_cnt <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_tx_pin    <= 1'b1;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cycle_cnt <= w_cycle_d;
            r_bit_cnt   <= w_bit_d;
            r_shift     <= w_shift_d;
            r_tx_pin    <= w_pin_d;
            r_ready     <= (w_state_d == S_IDLE);
            r_busy      <= (w_state_d != S_IDLE);
        end
    end

    assign tx_pin        = r_tx_pin;
    assign tx_data_ready = r_ready;
    assign tx_busy       = r_busy;

endmodule
